// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), total-length derivation
// and counter width helper for the Pong display path.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int line_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  // Never narrower than one bit so degenerate totals still elaborate.
  function automatic int cnt_w(int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register with a programmable reset value; used to align
// sync/active with renderer latency. DEPTH 0 degenerates to a wire.
module vga_sync_delay #(
  parameter int                DEPTH   = 2,
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, en};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe <= {DEPTH{RST_VAL}};
        end else if (en) begin
          pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign q = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and pin output stage: col/row counters, sync windows,
// latency-matched sync and blanked RGB. VGA_TIMING_FRAME_CNT_EN adds o_Frame_Count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   VIDEO_WIDTH = 3,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   VIDEO_DELAY = 2,
  localparam int  H_TOTAL     = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL     = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  CW          = cnt_w(H_TOTAL),
  localparam int  RW          = cnt_w(V_TOTAL)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_En,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [CW-1:0]          o_Col_Count,
  output logic [RW-1:0]          o_Row_Count,
  output logic                   o_Active,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,output logic [15:0]           o_Frame_Count
`endif
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [RW-1:0] V_LAST = RW'(V_TOTAL - 1);
  localparam logic [RW-1:0] V_ACT  = RW'(V_ACTIVE);
  localparam logic [RW-1:0] V_SS   = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] V_SE   = RW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last, row_last;

  assign col_last = (col == H_LAST);
  assign row_last = (row == V_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else if (i_En) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  logic hs_on, vs_on, active, raw_hs, raw_vs;

  assign hs_on  = (col >= H_SS) && (col <= H_SE);
  assign vs_on  = (row >= V_SS) && (row <= V_SE);
  assign active = (col < H_ACT) && (row < V_ACT);
  assign raw_hs = hs_on ? SYNC_POL : ~SYNC_POL;
  assign raw_vs = vs_on ? SYNC_POL : ~SYNC_POL;

  assign o_Col_Count   = col;
  assign o_Row_Count   = row;
  assign o_Active      = active;
  assign o_Line_Start  = (col == '0);
  assign o_Frame_Start = (col == '0) && (row == '0);

  // Pipeline resets to idle sync and blanked video so no stale pulse escapes.
  logic [2:0] dly_q;
  logic       dly_hs, dly_vs, dly_act;

  vga_sync_delay #(
    .DEPTH  (VIDEO_DELAY),
    .WIDTH  (3),
    .RST_VAL({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_delay (
    .clk(i_Clk),
    .rst(i_Rst),
    .en (i_En),
    .d  ({raw_hs, raw_vs, active}),
    .q  (dly_q)
  );

  assign {dly_hs, dly_vs, dly_act} = dly_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync     <= ~SYNC_POL;
      o_VSync     <= ~SYNC_POL;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else if (i_En) begin
      o_HSync     <= dly_hs;
      o_VSync     <= dly_vs;
      o_Red_Video <= dly_act ? i_Red_Video : '0;
      o_Grn_Video <= dly_act ? i_Grn_Video : '0;
      o_Blu_Video <= dly_act ? i_Blu_Video : '0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                             o_Frame_Count <= '0;
    else if (i_En && col_last && row_last) o_Frame_Count <= o_Frame_Count + 16'd1;
  end
`else
  // Frame counter not built.
`endif

endmodule
